// File: rtl/main_cntr_mc_if.sv
// Bus bundle for main_cntr_mc: select requests and load from the controller,
// per-channel enables and selects back to it.
interface main_cntr_mc_if #(
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 4
) ();
  logic                    cntr_clr;
  logic [NUM_CH-1:0]       fpp;
  logic [NUM_CH-1:0]       fmm;
  logic [NUM_CH-1:0]       ld;
  logic [SEL_W-1:0]        ld_sel;
  logic [NUM_CH-1:0]       en_clk;
  logic [NUM_CH-1:0]       en_pls;
  logic [NUM_CH*SEL_W-1:0] sel_o;

  modport master (
    output cntr_clr, fpp, fmm, ld, ld_sel,
    input  en_clk, en_pls, sel_o
  );

  modport slave (
    input  cntr_clr, fpp, fmm, ld, ld_sel,
    output en_clk, en_pls, sel_o
  );
endinterface

// File: rtl/main_cntr_mc.sv
// Multi-channel enable generator: one shared free-running counter, and per
// channel a divide-select producing a square enable and a one-cycle tick.
module main_cntr_mc #(
  parameter int CNT_W   = 16,
  parameter int NUM_CH  = 2,
  parameter int SEL_W   = 4,
  parameter int RST_SEL = CNT_W - 1
) (
  input  logic           clk,
  input  logic           rst,
  main_cntr_mc_if.slave  bus
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(CNT_W - 1);
  localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(RST_SEL);

  logic [CNT_W-1:0]             cntr;
  logic [NUM_CH-1:0][SEL_W-1:0] sel_q;
  logic [NUM_CH-1:0][SEL_W-1:0] sel_d;
  logic [NUM_CH-1:0]            fpp_q;
  logic [NUM_CH-1:0]            fmm_q;
  logic [NUM_CH-1:0]            up;
  logic [NUM_CH-1:0]            dn;
  logic [NUM_CH-1:0]            pls_d;
  logic [NUM_CH-1:0]            en_pls_q;
  logic [NUM_CH-1:0]            en_clk_w;

  assign up = bus.fpp & ~fpp_q;
  assign dn = bus.fmm & ~fmm_q;

  // Ones in bits [s:0]; the tick fires when those bits equal 0111..1, i.e.
  // one count before bit s of the counter rises.
  function automatic logic [CNT_W-1:0] low_mask(input logic [SEL_W-1:0] s);
    return {CNT_W{1'b1}} >> (CNT_W - 1 - int'(s));
  endfunction

  always_comb begin
    logic [CNT_W-1:0] mask;
    logic [CNT_W-1:0] shifted;
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a value held over and no latch is inferred.
    sel_d    = sel_q;
    pls_d    = '0;
    en_clk_w = '0;
    mask     = '0;
    shifted  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ld[i]) begin
        sel_d[i] = (bus.ld_sel > SEL_MAX) ? SEL_MAX : bus.ld_sel;
      end else if (up[i] && dn[i]) begin
        sel_d[i] = sel_q[i];
      end else if (up[i]) begin
        sel_d[i] = (sel_q[i] >= SEL_MAX) ? SEL_MAX : sel_q[i] + SEL_W'(1);
      end else if (dn[i]) begin
        sel_d[i] = (sel_q[i] == '0) ? '0 : sel_q[i] - SEL_W'(1);
      end

      mask        = low_mask(sel_q[i]);
      pls_d[i]    = ((cntr & mask) == (mask >> 1)) && !bus.cntr_clr;
      shifted     = cntr >> sel_q[i];
      en_clk_w[i] = shifted[0];
    end
  end

  // NOTE: state registers use non-blocking assignments only, with the
  // synchronous active-low reset as the first branch so it overrides all inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cntr     <= '0;
      sel_q    <= {NUM_CH{SEL_RST}};
      fpp_q    <= '1;
      fmm_q    <= '1;
      en_pls_q <= '0;
    end else begin
      cntr     <= bus.cntr_clr ? '0 : cntr + CNT_W'(1);
      sel_q    <= sel_d;
      fpp_q    <= bus.fpp;
      fmm_q    <= bus.fmm;
      en_pls_q <= pls_d;
    end
  end

  assign bus.en_clk = en_clk_w;
  assign bus.en_pls = en_pls_q;
  assign bus.sel_o  = sel_q;

endmodule

// File: tb/tb_main_cntr_mc.sv
// Directed bench for main_cntr_mc: a default 16-bit/2-channel instance plus a
// narrow 10-bit/1-channel instance for load saturation and counter wrap.
module tb_main_cntr_mc;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  main_cntr_mc_if #(.NUM_CH(2), .SEL_W(4)) bus ();
  main_cntr_mc_if #(.NUM_CH(1), .SEL_W(4)) bus_s ();

  main_cntr_mc #(.CNT_W(16), .NUM_CH(2), .SEL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  main_cntr_mc #(.CNT_W(10), .NUM_CH(1), .SEL_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, high, last, first0, first1, min_sp, max_sp;
    logic prev;

    rst          = 1'b0;
    bus.cntr_clr = 1'b0;
    bus.fpp      = 2'b01;
    bus.fmm      = 2'b10;
    bus.ld       = '0;
    bus.ld_sel   = '0;
    bus_s.cntr_clr = 1'b0;
    bus_s.fpp      = '0;
    bus_s.fmm      = '0;
    bus_s.ld       = '0;
    bus_s.ld_sel   = '0;

    // T1: reset with requests held; releasing must not step the selects
    tick(3);
    check("t1_sel_rst",   bus.sel_o, 8'hFF);
    check("t1_cntr_rst",  dut.cntr, 0);
    check("t1_pls_rst",   bus.en_pls, 0);
    check("t1_clk_rst",   bus.en_clk, 0);
    check("t1_sel_rst_s", bus_s.sel_o, 9);
    rst = 1'b1;
    tick(2);
    check("t1_no_step", bus.sel_o, 8'hFF);
    bus.fpp = '0;
    bus.fmm = '0;
    tick();

    // T2: sel0=0 -> en_clk toggles every cycle, tick on each high cycle
    bus.ld = 2'b01; bus.ld_sel = 4'd0; bus.cntr_clr = 1'b1;
    tick();
    bus.ld = '0; bus.cntr_clr = 1'b0;
    check("t2_sel",  bus.sel_o, 8'hF0);
    check("t2_cntr", dut.cntr, 0);
    check("t2_pls0", bus.en_pls, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t2_clk0", bus.en_clk[0], k[0]);
      check("t2_pls0", bus.en_pls[0], k[0]);
    end
    check("t2_pls1_idle", bus.en_pls[1], 0);

    // T3: sel0=3 over 64 cycles -> 4 ticks 16 apart, 32 high cycles
    bus.ld = 2'b01; bus.ld_sel = 4'd3; bus.cntr_clr = 1'b1;
    tick();
    bus.ld = '0; bus.cntr_clr = 1'b0;
    check("t3_sel", bus.sel_o, 8'hF3);
    pulses = 0; high = 0; last = 0;
    prev = bus.en_clk[0];
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (bus.en_pls[0]) begin
        pulses++;
        if (last == 0) check("t3_first_pls", k, 8);
        else           check("t3_spacing", k - last, 16);
        check("t3_pls_on_rise_hi", bus.en_clk[0], 1);
        check("t3_pls_on_rise_lo", prev, 0);
        last = k;
      end
      high += int'(bus.en_clk[0]);
      prev = bus.en_clk[0];
    end
    check("t3_pulses", pulses, 4);
    check("t3_high",   high, 32);

    // T4: held fpp steps once and saturates; repeated fmm saturates at 0
    bus.ld = 2'b10; bus.ld_sel = 4'd14;
    tick();
    bus.ld = '0;
    check("t4_sel_ld", bus.sel_o[7:4], 14);
    bus.fpp = 2'b10;
    tick();
    check("t4_up_once", bus.sel_o[7:4], 15);
    tick(9);
    check("t4_up_held", bus.sel_o[7:4], 15);
    bus.fpp = '0;
    tick();
    for (int p = 1; p <= 20; p++) begin
      bus.fmm = 2'b10;
      tick();
      bus.fmm = '0;
      tick();
      if (p == 1)  check("t4_dn_1",  bus.sel_o[7:4], 14);
      if (p == 15) check("t4_dn_15", bus.sel_o[7:4], 0);
    end
    check("t4_dn_sat", bus.sel_o[7:4], 0);
    check("t4_ch0_indep", bus.sel_o[3:0], 3);

    // T5: up+down together -> no change; load beats fpp; load saturates
    bus.fpp = 2'b01; bus.fmm = 2'b01;
    tick();
    check("t5_both", bus.sel_o[3:0], 3);
    bus.fpp = '0; bus.fmm = '0;
    tick();
    bus.ld = 2'b01; bus.ld_sel = 4'd7; bus.fpp = 2'b01;
    tick();
    check("t5_ld_wins", bus.sel_o[3:0], 7);
    bus.ld = '0; bus.fpp = '0;
    tick();
    check("t5_fall_no_step", bus.sel_o[3:0], 7);
    bus_s.ld = 1'b1; bus_s.ld_sel = 4'd13;
    tick();
    check("t5_ld_sat", bus_s.sel_o, 9);
    bus_s.ld_sel = 4'd5;
    tick();
    check("t5_ld_in_range", bus_s.sel_o, 5);
    bus_s.ld = 1'b0; bus_s.fpp = 1'b1;
    tick(3);
    check("t5_s_up_once", bus_s.sel_o, 6);
    bus_s.fpp = 1'b0;

    // Counter wrap on the 10-bit instance: sel=1 ticks every 4 cycles, no gap
    bus_s.ld = 1'b1; bus_s.ld_sel = 4'd1; bus_s.cntr_clr = 1'b1;
    tick();
    bus_s.ld = 1'b0; bus_s.cntr_clr = 1'b0;
    pulses = 0; last = 0; min_sp = 1 << 20; max_sp = 0;
    for (int k = 1; k <= 1030; k++) begin
      tick();
      if (bus_s.en_pls[0]) begin
        if (last != 0) begin
          if (k - last < min_sp) min_sp = k - last;
          if (k - last > max_sp) max_sp = k - last;
        end
        pulses++;
        last = k;
      end
    end
    check("wrap_pulses", pulses, 258);
    check("wrap_min_sp", min_sp, 4);
    check("wrap_max_sp", max_sp, 4);

    // T6: cntr_clr mid-run suppresses the due tick and realigns both channels
    bus.ld = 2'b01; bus.ld_sel = 4'd2; bus.cntr_clr = 1'b1;
    tick();
    bus.cntr_clr = 1'b0; bus.ld = 2'b10; bus.ld_sel = 4'd5;
    tick();
    bus.ld = '0;
    check("t6_sels", bus.sel_o, 8'h52);
    tick(10);
    check("t6_cntr_pre", dut.cntr, 11);
    bus.cntr_clr = 1'b1;
    tick();
    bus.cntr_clr = 1'b0;
    check("t6_cntr_clr", dut.cntr, 0);
    check("t6_no_pls", bus.en_pls, 0);
    first0 = 0; first1 = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.en_pls[0] && first0 == 0) first0 = k;
      if (bus.en_pls[1] && first1 == 0) first1 = k;
    end
    check("t6_first_ch0", first0, 4);
    check("t6_first_ch1", first1, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
